// File: rtl/reg_share_arb.sv
// One shared WIDTH-bit holding register fed by NREQ requesters through a
// round-robin arbiter, presented downstream with a valid/ack handshake.
module reg_share_arb #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [ID_W-1:0]       q_src,
    input  logic                  q_ack,
    output logic                  busy
);

    logic [ID_W-1:0]  ptr_r;
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;
    logic [ID_W-1:0]  q_src_r;

    logic [ID_W-1:0]  winner_s;
    logic             found_s;
    logic             can_load_s;
    logic [NREQ-1:0]  gnt_s;
    logic [ID_W-1:0]  ptr_next_s;

    // Round-robin scan starting at ptr_r; the first active request wins.
    always_comb begin
        winner_s = {ID_W{1'b0}};
        found_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_r) + k) % NREQ;
            if (!found_s && req[idx]) begin
                winner_s = ID_W'(idx);
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
                found_s  = found_s;
            end
        end
    end

    // Grant only when the slot can take data, and never while reset is held.
    always_comb begin
        can_load_s = ~q_valid_r | q_ack;
        if (rst && can_load_s && found_s) begin
            gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            gnt_s = {NREQ{1'b0}};
        end
    end

    // Next pointer position: one past the winner, wrapping at NREQ-1.
    always_comb begin
        if (winner_s == ID_W'(NREQ - 1)) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = winner_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    // Holding register, source tag, valid flag and arbitration pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r       <= {WIDTH{1'b0}};
            q_valid_r <= 1'b0;
            q_src_r   <= {ID_W{1'b0}};
            ptr_r     <= {ID_W{1'b0}};
        end else if (|gnt_s) begin
            q_r       <= req_data[winner_s*WIDTH +: WIDTH];
            q_src_r   <= winner_s;
            q_valid_r <= 1'b1;
            ptr_r     <= ptr_next_s;
        end else if (q_valid_r && q_ack) begin
            // Consumed with nobody waiting: slot drains, contents retained.
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= q_valid_r;
        end
    end

    assign gnt     = gnt_s;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign q_src   = q_src_r;
    assign busy    = q_valid_r | (|req);

endmodule
